// File: rtl/id_ex_ctrl_stage.sv
// ID/EX pipeline register for control, PC and register fields, with load-use hazard detection.
// Latency: one cycle from ID inputs to EX outputs; load_stall_o is combinational.
// Backpressure: hold_i freezes the stage; load_stall_o tells upstream to hold PC and IF/ID.
module id_ex_ctrl_stage (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [18:0] id_ctrl_i,
  input  logic        id_valid_i,
  input  logic [31:0] id_pc_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic [4:0]  id_rd_i,
  input  logic        flush_i,
  input  logic        hold_i,
  output logic [18:0] ex_ctrl_o,
  output logic [31:0] ex_pc_o,
  output logic [4:0]  ex_rs_o,
  output logic [4:0]  ex_rt_o,
  output logic [4:0]  ex_wreg_o,
  output logic        ex_valid_o,
  output logic        load_stall_o,
  output logic [15:0] stall_cnt_o
);

  // Control bundle bit positions used inside this stage.
  localparam int unsigned CtrlMemToReg = 6;
  localparam int unsigned CtrlJal      = 9;
  localparam int unsigned CtrlRegDst   = 4;
  localparam int unsigned CtrlRegWrite = 3;

  logic [18:0] ex_ctrl_q,  ex_ctrl_d;
  logic [31:0] ex_pc_q,    ex_pc_d;
  logic [4:0]  ex_rs_q,    ex_rs_d;
  logic [4:0]  ex_rt_q,    ex_rt_d;
  logic [4:0]  ex_wreg_q,  ex_wreg_d;
  logic        ex_valid_q, ex_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [4:0]  id_wreg;
  logic        load_stall;

  // Destination register of the ID instruction: JAL links to $31, otherwise rd/rt, zero if no write.
  always_comb begin
    id_wreg = id_rt_i;
    if (id_ctrl_i[CtrlJal]) begin
      id_wreg = 5'd31;
    end else if (id_ctrl_i[CtrlRegDst]) begin
      id_wreg = id_rd_i;
    end
    if (!id_ctrl_i[CtrlRegWrite]) begin
      id_wreg = 5'd0;
    end
  end

  // Load in EX whose result the ID instruction reads; $0 destinations never hazard.
  always_comb begin
    load_stall = ex_valid_q & ex_ctrl_q[CtrlMemToReg] & (ex_wreg_q != 5'd0) & id_valid_i &
                 ((ex_wreg_q == id_rs_i) | (ex_wreg_q == id_rt_i));
  end

  // Next-state selection: flush beats hold, hold beats stall, otherwise capture ID.
  always_comb begin
    ex_ctrl_d   = ex_ctrl_q;
    ex_pc_d     = ex_pc_q;
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_wreg_d   = ex_wreg_q;
    ex_valid_d  = ex_valid_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i || (!hold_i && (load_stall || !id_valid_i))) begin
      // Bubble: flush, load-use stall, or nothing real in ID.
      ex_ctrl_d  = '0;
      ex_pc_d    = '0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      ex_wreg_d  = '0;
      ex_valid_d = 1'b0;
    end else if (!hold_i) begin
      ex_ctrl_d  = id_ctrl_i;
      ex_pc_d    = id_pc_i;
      ex_rs_d    = id_rs_i;
      ex_rt_d    = id_rt_i;
      ex_wreg_d  = id_wreg;
      ex_valid_d = 1'b1;
    end
    // Count only bubbles actually caused by the load-use hazard; saturate at all-ones.
    if (!flush_i && !hold_i && load_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stage registers, cleared to the bubble state by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_ctrl_q   <= '0;
      ex_pc_q     <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_wreg_q   <= '0;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      ex_pc_q     <= ex_pc_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_wreg_q   <= ex_wreg_d;
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_ctrl_o    = ex_ctrl_q;
  assign ex_pc_o      = ex_pc_q;
  assign ex_rs_o      = ex_rs_q;
  assign ex_rt_o      = ex_rt_q;
  assign ex_wreg_o    = ex_wreg_q;
  assign ex_valid_o   = ex_valid_q;
  assign load_stall_o = load_stall;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Testbench for id_ex_ctrl_stage: directed scenarios plus randomized traffic
// against a behavioural model of the ID/EX register and load-use hazard rules.
module tb_id_ex_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] id_ctrl;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        flush, hold;
  logic [18:0] ex_ctrl;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs, ex_rt, ex_wreg;
  logic        ex_valid, load_stall;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model of what EX should hold.
  logic [18:0] m_ctrl;
  logic [31:0] m_pc;
  logic [4:0]  m_rs, m_rt, m_wreg;
  logic        m_valid;
  int          m_cnt;

  id_ex_ctrl_stage dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .id_ctrl_i   (id_ctrl),
    .id_valid_i  (id_valid),
    .id_pc_i     (id_pc),
    .id_rs_i     (id_rs),
    .id_rt_i     (id_rt),
    .id_rd_i     (id_rd),
    .flush_i     (flush),
    .hold_i      (hold),
    .ex_ctrl_o   (ex_ctrl),
    .ex_pc_o     (ex_pc),
    .ex_rs_o     (ex_rs),
    .ex_rt_o     (ex_rt),
    .ex_wreg_o   (ex_wreg),
    .ex_valid_o  (ex_valid),
    .load_stall_o(load_stall),
    .stall_cnt_o (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] dest_of(logic [18:0] c, logic [4:0] rt, logic [4:0] rd);
    if (!c[3]) return 5'd0;
    if (c[9])  return 5'd31;
    return c[4] ? rd : rt;
  endfunction

  function automatic bit model_stall();
    return m_valid && m_ctrl[6] && (m_wreg != 0) && id_valid && (m_wreg == id_rs || m_wreg == id_rt);
  endfunction

  task automatic model_clear();
    m_ctrl = '0; m_pc = '0; m_rs = '0; m_rt = '0; m_wreg = '0; m_valid = 1'b0;
  endtask

  // One rising edge with the current inputs; the model follows, outputs sampled 1 time unit later.
  task automatic tick();
    bit st;
    st = model_stall();
    @(posedge clk);
    if (flush) model_clear();
    else if (hold) begin end
    else if (st) begin
      model_clear();
      if (m_cnt < 65535) m_cnt++;
    end else if (id_valid) begin
      m_ctrl = id_ctrl; m_pc = id_pc; m_rs = id_rs; m_rt = id_rt;
      m_wreg = dest_of(id_ctrl, id_rt, id_rd); m_valid = 1'b1;
    end else model_clear();
    #1;
  endtask

  task automatic set_id(logic v, logic [18:0] c, logic [31:0] pc,
                        logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    id_valid = v; id_ctrl = c; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; hold = 0; m_cnt = 0; model_clear();
    set_id(1, 19'h0001C, 32'h100, 5'd1, 5'd2, 5'd3);
    #2;
    checks++;
    if ({ex_ctrl, ex_pc, ex_rs, ex_rt, ex_wreg, ex_valid, load_stall, stall_cnt} !== '0) begin
      errors++; $display("FAIL reset_initial: outputs=%h required 0",
        {ex_ctrl, ex_pc, ex_rs, ex_rt, ex_wreg, ex_valid, load_stall, stall_cnt});
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++;
    if (ex_valid !== 1'b1) begin errors++; $display("FAIL reset_preload: ex_valid=%b required 1", ex_valid); end
    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_ctrl, ex_pc, ex_rs, ex_rt, ex_wreg, ex_valid, load_stall, stall_cnt} !== '0) begin
      errors++; $display("FAIL reset_async: outputs=%h required 0",
        {ex_ctrl, ex_pc, ex_rs, ex_rt, ex_wreg, ex_valid, load_stall, stall_cnt});
    end
    model_clear(); m_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    set_id(1, 19'h0001C, 32'h00003000, 5'd4, 5'd5, 5'd8);
    tick();
    checks++;
    if (ex_ctrl !== 19'h0001C || ex_wreg !== 5'd8 || ex_pc !== 32'h00003000 || ex_valid !== 1'b1 ||
        ex_rs !== 5'd4 || ex_rt !== 5'd5) begin
      errors++; $display("FAIL pass_through: ctrl=%h wreg=%0d pc=%h v=%b rs=%0d rt=%0d required 0001c 8 00003000 1 4 5",
        ex_ctrl, ex_wreg, ex_pc, ex_valid, ex_rs, ex_rt);
    end
    // ID_VALID low stores a bubble regardless of control.
    set_id(0, 19'h7FFFF, 32'hDEAD0000, 5'd1, 5'd2, 5'd3);
    tick();
    checks++;
    if ({ex_ctrl, ex_pc, ex_wreg, ex_valid} !== '0) begin
      errors++; $display("FAIL invalid_bubble: ctrl=%h pc=%h wreg=%0d v=%b required all 0", ex_ctrl, ex_pc, ex_wreg, ex_valid);
    end
  endtask

  task automatic test_load_use();
    // lw $9: MemToReg + RegWrite, RegDst=0, rt=9.
    set_id(1, 19'h00048, 32'h00003004, 5'd2, 5'd9, 5'd0);
    tick();
    set_id(1, 19'h0001C, 32'h00003008, 5'd9, 5'd3, 5'd10);
    #1;
    checks++;
    if (load_stall !== 1'b1) begin errors++; $display("FAIL load_use_detect: load_stall=%b required 1", load_stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || stall_cnt !== 16'd1 || load_stall !== 1'b0) begin
      errors++; $display("FAIL load_use_bubble: v=%b cnt=%0d stall=%b required 0 1 0", ex_valid, stall_cnt, load_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h00003008 || ex_wreg !== 5'd10) begin
      errors++; $display("FAIL load_use_resume: v=%b pc=%h wreg=%0d required 1 00003008 10", ex_valid, ex_pc, ex_wreg);
    end
  endtask

  task automatic test_priority();
    logic [18:0] c0; logic [31:0] p0; logic [4:0] w0;
    // Flush together with a live load-use hazard: bubble, counter untouched.
    set_id(1, 19'h00048, 32'h00004000, 5'd1, 5'd7, 5'd0);
    tick();
    set_id(1, 19'h0001C, 32'h00004004, 5'd7, 5'd7, 5'd11);
    flush = 1; hold = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL flush_over_hold: v=%b ctrl=%h cnt=%0d required 0 0 1", ex_valid, ex_ctrl, stall_cnt);
    end
    flush = 0; hold = 0;
    set_id(1, 19'h0001C, 32'h00004008, 5'd12, 5'd13, 5'd14);
    tick();
    c0 = ex_ctrl; p0 = ex_pc; w0 = ex_wreg;
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
      tick();
      checks++;
      if (ex_ctrl !== 19'h0001C || ex_pc !== 32'h00004008 || ex_wreg !== 5'd14 || ex_valid !== 1'b1) begin
        errors++; $display("FAIL hold_keep%0d: ctrl=%h pc=%h wreg=%0d v=%b required 0001c 00004008 14 1",
          i, ex_ctrl, ex_pc, ex_wreg, ex_valid);
      end
    end
    hold = 0;
  endtask

  task automatic test_jal_regwrite();
    set_id(1, 19'h00208, 32'h00005000, 5'd0, 5'd0, 5'd5);
    tick();
    checks++;
    if (ex_wreg !== 5'd31) begin errors++; $display("FAIL jal_dest: wreg=%0d required 31", ex_wreg); end
    set_id(1, 19'h00030, 32'h00005004, 5'd4, 5'd6, 5'd7);
    tick();
    checks++;
    if (ex_wreg !== 5'd0) begin errors++; $display("FAIL store_dest: wreg=%0d required 0", ex_wreg); end
    set_id(1, 19'h00048, 32'h00005008, 5'd4, 5'd0, 5'd0);
    tick();
    set_id(1, 19'h0001C, 32'h0000500C, 5'd0, 5'd0, 5'd2);
    #1;
    checks++;
    if (load_stall !== 1'b0) begin errors++; $display("FAIL lw_zero_nostall: load_stall=%b required 0", load_stall); end
    tick();
  endtask

  task automatic test_random();
    logic [18:0] c;
    for (int n = 0; n < 600; n++) begin
      c = 19'($urandom);
      if ($urandom_range(0, 2) == 0) c = (c & ~19'h00010) | 19'h00048;
      set_id(($urandom_range(0, 7) != 0), c, $urandom,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 15) == 0);
      hold  = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (load_stall !== model_stall()) begin
        errors++; $display("FAIL rand_stall n=%0d: load_stall=%b required %b", n, load_stall, model_stall());
      end
      tick();
      checks++;
      if ({ex_ctrl, ex_pc, ex_rs, ex_rt, ex_wreg, ex_valid, stall_cnt} !==
          {m_ctrl, m_pc, m_rs, m_rt, m_wreg, m_valid, 16'(m_cnt)}) begin
        errors++; $display("FAIL rand_state n=%0d: got %h/%h/%0d/%0d/%0d/%b/%0d required %h/%h/%0d/%0d/%0d/%b/%0d", n,
          ex_ctrl, ex_pc, ex_rs, ex_rt, ex_wreg, ex_valid, stall_cnt,
          m_ctrl, m_pc, m_rs, m_rt, m_wreg, m_valid, m_cnt);
      end
    end
    flush = 0; hold = 0;
  endtask

  task automatic test_saturation();
    // Preload the counter near the top so saturation is reached in a handful of real stalls.
    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFFC;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 16'hFFFC;
    set_id(0, '0, '0, '0, '0, '0);
    tick();
    for (int k = 0; k < 6; k++) begin
      set_id(1, 19'h00048, 32'h00006000, 5'd1, 5'd17, 5'd0);
      tick();
      set_id(1, 19'h0001C, 32'h00006004, 5'd17, 5'd2, 5'd3);
      tick();
      checks++;
      if (stall_cnt !== 16'(m_cnt) || ex_valid !== 1'b0) begin
        errors++; $display("FAIL saturate%0d: cnt=%h v=%b required %h 0", k, stall_cnt, ex_valid, 16'(m_cnt));
      end
    end
    checks++;
    if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL saturate_final: cnt=%h required ffff", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_priority();
    test_jal_regwrite();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
